// File: rtl/axi_write_arbiter.sv
// Write-path arbiter for M1: walks one transaction through AW, W and B towards S0, S1
// or the built-in default slave, and drives the crossbar phase-select codes.
module axi_write_arbiter #(
    parameter int unsigned ADDR_BITS = 32,
    parameter int unsigned LEN_BITS  = 4
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [ADDR_BITS-1:0] AWADDR_M1,
    input  logic [LEN_BITS-1:0]  AWLEN_M1,
    input  logic                 AWVALID_M1,
    input  logic                 AWREADY_S0,
    input  logic                 AWREADY_S1,
    input  logic                 WVALID_M1,
    input  logic                 WLAST_M1,
    input  logic                 WREADY_S0,
    input  logic                 WREADY_S1,
    input  logic                 BVALID_S0,
    input  logic                 BVALID_S1,
    input  logic                 BREADY_M1,
    output logic [2:0]           AW_state,
    output logic [2:0]           W_state,
    output logic [2:0]           B_state,
    output logic                 DS_AWREADY,
    output logic                 DS_WREADY,
    output logic                 DS_BVALID,
    output logic [1:0]           DS_BRESP,
    output logic                 WLAST_ERR
);

    localparam int unsigned CNT_BITS = LEN_BITS + 1;
    localparam int unsigned SEL_BITS = ADDR_BITS - 16;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_S0   = 3'd1;
    localparam logic [2:0] SEL_S1   = 3'd2;
    localparam logic [2:0] SEL_DS   = 3'd3;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [3:0] {
        IDLE,
        AW_S0,
        AW_S1,
        AW_DS,
        W_S0,
        W_S1,
        W_DS,
        B_S0,
        B_S1,
        B_DS
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [CNT_BITS-1:0] r_beat_cnt;
    logic [LEN_BITS-1:0] r_len;
    logic                r_wlast_err;

    logic [SEL_BITS-1:0] w_sel;
    logic                w_addr_unused;
    logic                w_ds_beat;
    logic                w_len_done;
    logic                w_ds_exit;

    // Only the upper address half selects the target; the low half is routed by the crossbar.
    assign w_sel         = AWADDR_M1[ADDR_BITS-1:16];
    assign w_addr_unused = ^AWADDR_M1[15:0];

    assign w_ds_beat  = (r_state == W_DS) && WVALID_M1;
    assign w_len_done = (r_beat_cnt == CNT_BITS'(r_len));
    assign w_ds_exit  = WLAST_M1 || w_len_done;

    // State register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Default-slave burst tracking and sticky WLAST/length disagreement flag
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_beat_cnt  <= '0;
            r_len       <= '0;
            r_wlast_err <= 1'b0;
        end else begin
            if ((r_state == AW_DS) && AWVALID_M1) begin
                r_len      <= AWLEN_M1;
                r_beat_cnt <= '0;
            end else if (w_ds_beat && !(&r_beat_cnt)) begin
                r_beat_cnt <= r_beat_cnt + CNT_BITS'(1);
            end
            if (w_ds_beat && (WLAST_M1 != w_len_done)) begin
                r_wlast_err <= 1'b1;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (AWVALID_M1) begin
                    if (w_sel == '0) begin
                        w_next = AW_S0;
                    end else if (w_sel == SEL_BITS'(1)) begin
                        w_next = AW_S1;
                    end else begin
                        w_next = AW_DS;
                    end
                end
            end
            AW_S0: if (AWVALID_M1 && AWREADY_S0) w_next = W_S0;
            AW_S1: if (AWVALID_M1 && AWREADY_S1) w_next = W_S1;
            AW_DS: if (AWVALID_M1) w_next = W_DS;
            W_S0:  if (WVALID_M1 && WREADY_S0 && WLAST_M1) w_next = B_S0;
            W_S1:  if (WVALID_M1 && WREADY_S1 && WLAST_M1) w_next = B_S1;
            W_DS:  if (WVALID_M1 && w_ds_exit) w_next = B_DS;
            B_S0:  if (BVALID_S0 && BREADY_M1) w_next = IDLE;
            B_S1:  if (BVALID_S1 && BREADY_M1) w_next = IDLE;
            B_DS:  if (BREADY_M1) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Phase-select codes and default-slave handshakes are pure state decodes
    always_comb begin
        AW_state   = SEL_NONE;
        W_state    = SEL_NONE;
        B_state    = SEL_NONE;
        DS_AWREADY = 1'b0;
        DS_WREADY  = 1'b0;
        DS_BVALID  = 1'b0;
        DS_BRESP   = RESP_OKAY;
        case (r_state)
            AW_S0: AW_state = SEL_S0;
            AW_S1: AW_state = SEL_S1;
            AW_DS: begin
                AW_state   = SEL_DS;
                DS_AWREADY = 1'b1;
            end
            W_S0:  W_state = SEL_S0;
            W_S1:  W_state = SEL_S1;
            W_DS: begin
                W_state   = SEL_DS;
                DS_WREADY = 1'b1;
            end
            B_S0:  B_state = SEL_S0;
            B_S1:  B_state = SEL_S1;
            B_DS: begin
                B_state   = SEL_DS;
                DS_BVALID = 1'b1;
                DS_BRESP  = RESP_DECERR;
            end
            default: ;
        endcase
    end

    assign WLAST_ERR = r_wlast_err;

endmodule

// File: tb/tb_axi_write_arbiter.sv
// Randomized bench for axi_write_arbiter against a transaction-phase reference model.
module tb_axi_write_arbiter;

    logic        ACLK;
    logic        ARESET;
    logic [31:0] AWADDR_M1;
    logic [3:0]  AWLEN_M1;
    logic        AWVALID_M1;
    logic        AWREADY_S0, AWREADY_S1;
    logic        WVALID_M1, WLAST_M1;
    logic        WREADY_S0, WREADY_S1;
    logic        BVALID_S0, BVALID_S1;
    logic        BREADY_M1;
    logic [2:0]  AW_state, W_state, B_state;
    logic        DS_AWREADY, DS_WREADY, DS_BVALID;
    logic [1:0]  DS_BRESP;
    logic        WLAST_ERR;

    axi_write_arbiter #(.ADDR_BITS(32), .LEN_BITS(4)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR_M1(AWADDR_M1), .AWLEN_M1(AWLEN_M1), .AWVALID_M1(AWVALID_M1),
        .AWREADY_S0(AWREADY_S0), .AWREADY_S1(AWREADY_S1),
        .WVALID_M1(WVALID_M1), .WLAST_M1(WLAST_M1),
        .WREADY_S0(WREADY_S0), .WREADY_S1(WREADY_S1),
        .BVALID_S0(BVALID_S0), .BVALID_S1(BVALID_S1), .BREADY_M1(BREADY_M1),
        .AW_state(AW_state), .W_state(W_state), .B_state(B_state),
        .DS_AWREADY(DS_AWREADY), .DS_WREADY(DS_WREADY), .DS_BVALID(DS_BVALID),
        .DS_BRESP(DS_BRESP), .WLAST_ERR(WLAST_ERR)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef enum int {PH_IDLE, PH_AW, PH_W, PH_B} phase_t;

    // Reference model: which phase the single outstanding transaction is in, and its target
    phase_t m_phase;
    int     m_tgt;
    int     m_len;
    int     m_beats;
    logic   m_err;

    int n_checks;
    int n_errors;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        logic [15:0] up;
        up = a[31:16];
        if (up == 16'h0000) return 1;
        if (up == 16'h0001) return 2;
        return 3;
    endfunction

    function automatic logic pick(input logic [1:0] v, input int t);
        return (t == 2) ? v[1] : v[0];
    endfunction

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_tgt   = 0;
        m_len   = 0;
        m_beats = 0;
        m_err   = 1'b0;
    endtask

    task automatic drive_zero();
        AWADDR_M1 = '0; AWLEN_M1 = '0; AWVALID_M1 = 1'b0;
        AWREADY_S0 = 1'b0; AWREADY_S1 = 1'b0;
        WVALID_M1 = 1'b0; WLAST_M1 = 1'b0; WREADY_S0 = 1'b0; WREADY_S1 = 1'b0;
        BVALID_S0 = 1'b0; BVALID_S1 = 1'b0; BREADY_M1 = 1'b0;
    endtask

    // Compare outputs with the model, then apply this cycle's inputs and advance the model
    task automatic step(input logic awv, input logic [31:0] addr, input logic [3:0] len,
                        input logic [1:0] awr, input logic wv, input logic wl,
                        input logic [1:0] wr, input logic [1:0] bv, input logic br);
        int  beat_no;
        logic full;
        @(negedge ACLK);
        check("aw_state", 32'(AW_state), (m_phase == PH_AW) ? 32'(m_tgt) : 32'd0);
        check("w_state",  32'(W_state),  (m_phase == PH_W)  ? 32'(m_tgt) : 32'd0);
        check("b_state",  32'(B_state),  (m_phase == PH_B)  ? 32'(m_tgt) : 32'd0);
        check("ds_awready", 32'(DS_AWREADY), 32'((m_phase == PH_AW) && (m_tgt == 3)));
        check("ds_wready",  32'(DS_WREADY),  32'((m_phase == PH_W)  && (m_tgt == 3)));
        check("ds_bvalid",  32'(DS_BVALID),  32'((m_phase == PH_B)  && (m_tgt == 3)));
        check("ds_bresp",   32'(DS_BRESP),   ((m_phase == PH_B) && (m_tgt == 3)) ? 32'd3 : 32'd0);
        check("wlast_err",  32'(WLAST_ERR),  32'(m_err));

        AWVALID_M1 = awv; AWADDR_M1 = addr; AWLEN_M1 = len;
        AWREADY_S0 = awr[0]; AWREADY_S1 = awr[1];
        WVALID_M1 = wv; WLAST_M1 = wl; WREADY_S0 = wr[0]; WREADY_S1 = wr[1];
        BVALID_S0 = bv[0]; BVALID_S1 = bv[1]; BREADY_M1 = br;

        case (m_phase)
            PH_IDLE: if (awv) begin
                m_phase = PH_AW;
                m_tgt   = decode(addr);
            end
            PH_AW: if (awv && ((m_tgt == 3) || pick(awr, m_tgt))) begin
                m_phase = PH_W;
                m_beats = 0;
                m_len   = int'(len);
            end
            PH_W: begin
                if (m_tgt == 3) begin
                    if (wv) begin
                        m_beats++;
                        beat_no = m_beats;
                        full = (beat_no == m_len + 1);
                        if (wl != full) m_err = 1'b1;
                        if (wl || full) m_phase = PH_B;
                    end
                end else if (wv && pick(wr, m_tgt)) begin
                    m_beats++;
                    if (wl) m_phase = PH_B;
                end
            end
            PH_B: if (br && ((m_tgt == 3) || pick(bv, m_tgt))) m_phase = PH_IDLE;
            default: ;
        endcase
    endtask

    task automatic idle_cycle();
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    endtask

    // Asynchronous reset pulse inside the low clock phase; outputs must clear before any edge
    task automatic do_reset();
        @(negedge ACLK);
        #1 ARESET = 1'b1;
        drive_zero();
        #1;
        check("rst_aw", 32'(AW_state), 32'd0);
        check("rst_w",  32'(W_state),  32'd0);
        check("rst_b",  32'(B_state),  32'd0);
        check("rst_ds", 32'({DS_AWREADY, DS_WREADY, DS_BVALID, DS_BRESP}), 32'd0);
        check("rst_err", 32'(WLAST_ERR), 32'd0);
        #1 ARESET = 1'b0;
        model_reset();
    endtask

    logic [31:0] r_addr;
    logic [3:0]  r_len;
    logic        awv, wv, wl, br;
    int          plan;

    initial begin
        n_checks = 0;
        n_errors = 0;
        ARESET   = 1'b1;
        drive_zero();
        model_reset();
        repeat (3) @(negedge ACLK);
        check("init_codes", 32'({AW_state, W_state, B_state}), 32'd0);
        ARESET = 1'b0;
        idle_cycle();

        // Single-beat write to S0
        step(1'b1, 32'h10, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b1, 32'h10, 4'd0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 32'h10, 4'd0, 2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
        step(1'b0, 32'h10, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1);
        idle_cycle();

        // 4-beat burst to S1 with WREADY toggling
        step(1'b1, 32'h0001_0000, 4'd3, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b1, 32'h0001_0000, 4'd3, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        for (int i = 0; i < 8; i++)
            step(1'b0, 32'h0001_0000, 4'd3, 2'b00, 1'b1, (m_beats == 3),
                 (i % 2 == 1) ? 2'b10 : 2'b00, 2'b00, 1'b0);
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1);
        idle_cycle();

        // Default slave, AWLEN=1, correct WLAST
        step(1'b1, 32'h0002_0000, 4'd1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b1, 32'h0002_0000, 4'd1, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
        idle_cycle();
        check("ds_ok_no_err", 32'(WLAST_ERR), 32'd0);

        // Default slave, AWLEN=2 but WLAST on beat 1; then a correct DS write
        step(1'b1, 32'h0003_0000, 4'd2, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b1, 32'h0003_0000, 4'd2, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
        step(1'b1, 32'hFFFF_0000, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b1, 32'hFFFF_0000, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
        idle_cycle();
        check("ds_err_sticky", 32'(WLAST_ERR), 32'd1);

        // BREADY held low for 5 cycles in B_S0
        step(1'b1, 32'h20, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b1, 32'h20, 4'd0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
        repeat (5) step(1'b0, 32'h0, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0);
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1);
        idle_cycle();

        // Reset in W_S1 mid-burst, then a normal S0 decode
        step(1'b1, 32'h0001_0040, 4'd3, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b1, 32'h0001_0040, 4'd3, 2'b10, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0);
        idle_cycle();
        do_reset();
        step(1'b1, 32'h30, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b1, 32'h30, 4'd0, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b1, 1'b1, 2'b01, 2'b00, 1'b0);
        step(1'b0, 32'h0, 4'd0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1);
        idle_cycle();

        // Random traffic
        r_addr = '0;
        r_len  = '0;
        plan   = 1;
        for (int n = 0; n < 4000; n++) begin
            if (($urandom % 700) == 0) do_reset();
            if (m_phase == PH_IDLE) begin
                case ($urandom % 4)
                    0: r_addr = {16'h0000, 16'($urandom)};
                    1: r_addr = {16'h0001, 16'($urandom)};
                    2: r_addr = {16'($urandom_range(2, 65535)), 16'($urandom)};
                    default: r_addr = $urandom;
                endcase
                r_len = 4'($urandom_range(0, 15));
                awv   = ($urandom % 4) != 0;
                if (awv) begin
                    if ((decode(r_addr) == 3) && (($urandom % 3) == 0))
                        plan = $urandom_range(1, 16);
                    else
                        plan = int'(r_len) + 1;
                end
            end else begin
                awv = ($urandom % 8) != 0;
            end
            wv = ($urandom % 10) < 7;
            wl = wv && (m_beats + 1 == plan);
            br = ($urandom % 3) != 0;
            step(awv, r_addr, r_len, 2'($urandom), wv, wl, 2'($urandom), 2'($urandom), br);
        end
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi_write_arbiter.md
Name: axi_write_arbiter

Overview:
- Write-path arbiter/router for the AXI interconnect; it is the write-direction counterpart of the read arbiter.
- Serialises one write transaction at a time from master M1 (data port) through the AW, W and B phases to slave S0 or S1, selected by address.
- Contains an integrated default slave. Writes to unmapped addresses are accepted, their data is drained, and they are answered with DECERR.
- Outputs are phase-select codes that drive the AW/W/B crossbar muxes, plus the default-slave handshake signals.

Parameters:
- ADDR_BITS, 32, AW address width (matches AXI_ADDR_BITS).
- LEN_BITS, 4, AWLEN width.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset; one clock; reset is asynchronous and active-high.
- AWADDR_M1  in  ADDR_BITS  write address from M1.
- AWLEN_M1  in  LEN_BITS  burst length minus 1.
- AWVALID_M1  in  1  address valid.
- AWREADY_S0, AWREADY_S1  in  1 each  slave address ready.
- WVALID_M1  in  1  write data valid.
- WLAST_M1  in  1  last beat.
- WREADY_S0, WREADY_S1  in  1 each  slave data ready.
- BVALID_S0, BVALID_S1  in  1 each  slave response valid.
- BREADY_M1  in  1  master response ready.
- AW_state  out  3  0 = none, 1 = S0, 2 = S1, 3 = default slave.
- W_state  out  3  same encoding.
- B_state  out  3  same encoding.
- DS_AWREADY  out  1  default-slave AWREADY.
- DS_WREADY  out  1  default-slave WREADY.
- DS_BVALID  out  1  default-slave BVALID.
- DS_BRESP  out  2  default-slave BRESP.
- WLAST_ERR  out  1  sticky: WLAST did not coincide with the AWLEN-th beat in the default slave.

Behaviour:
- States: IDLE, AW_S0, AW_S1, AW_DS, W_S0, W_S1, W_DS, B_S0, B_S1, B_DS. Registered state; all outputs decoded combinationally from state.
- Reset (async, ARESET=1): state=IDLE, beat counter=0, latched length=0, WLAST_ERR=0. All outputs 0. Reset mid-transaction abandons it with no response.
- IDLE: if AWVALID_M1, decode AWADDR_M1[31:16]: 0 -> AW_S0; 1 -> AW_S1; any other -> AW_DS. Otherwise stay.
- Decode latency: 1 cycle. AW_state becomes valid the cycle after AWVALID is first seen in IDLE.
- AW_Sx: stay until AWVALID_M1 && AWREADY_Sx, then go to W_Sx.
- AW_DS: DS_AWREADY=1. On AWVALID_M1, latch AWLEN_M1, clear the beat counter, go to W_DS.
- W_Sx: stay until WVALID_M1 && WREADY_Sx && WLAST_M1, then go to B_Sx. Non-last beats do not change state.
- W_DS: DS_WREADY=1. Each WVALID_M1 beat increments the counter (LEN_BITS+1 wide, no wrap).
  - Exit to B_DS on the beat where WLAST_M1=1 OR counter==latched length, whichever comes first.
  - If those two conditions disagree on that beat, set WLAST_ERR=1. It stays set until reset.
- B_Sx: stay until BVALID_Sx && BREADY_M1, then go to IDLE.
- B_DS: DS_BVALID=1, DS_BRESP=2'b11 (DECERR). On BREADY_M1, go to IDLE. DS_BRESP=2'b00 in all other states.
- Phase codes:
  - AW_state is non-zero only in AW_* states.
  - W_state is non-zero only in W_* states.
  - B_state is non-zero only in B_* states.
  - At most one of the three is non-zero in any cycle.
- Phase handshake timing: AW->W->B. Each phase handshake takes effect at the clock edge. The next phase's code is visible the following cycle, so there is no combinational ready->valid path.
- Back-to-back transactions: after B completes the state returns to IDLE. A new AWVALID is decoded in the next cycle, giving a minimum 1 idle cycle between transactions.
- Early write data: WVALID asserted during an AW phase is ignored; W_state=0, so the master sees no WREADY.
- Slave ready held low indefinitely: the block waits with no timeout.

Test Plan:
- Single-beat write to 0x0000_0010: AWVALID in IDLE -> AW_state=1 next cycle. AWREADY_S0 -> W_state=1. WVALID+WLAST+WREADY_S0 -> B_state=1. BVALID_S0+BREADY -> IDLE, all codes 0.
- 4-beat burst to 0x0001_0000 (AWLEN=3), WREADY_S1 toggling every cycle -> W_state=2 held through all 4 beats; B phase is entered only after the WLAST handshake.
- Write to 0x0002_0000, AWLEN=1 -> AW_state=3, DS_AWREADY=1. Two beats with WLAST on beat 2 -> DS_WREADY=1 throughout. Then DS_BVALID=1, DS_BRESP=3. WLAST_ERR stays 0.
- Default-slave length mismatch: AWLEN=2, WLAST on beat 1 -> go to B_DS after beat 1 and WLAST_ERR=1. A second, correct DS write leaves WLAST_ERR=1.
- BREADY_M1 held low 5 cycles in B_S0 with BVALID_S0=1 -> B_state stays 1. Release -> IDLE next cycle.
- ARESET pulsed in W_S1 mid-burst -> all outputs 0 asynchronously, state IDLE. A following AWVALID to S0 is decoded normally.
